// File: rtl/instr_buffer.sv
// Instruction buffer between fetch and decode. It is a circular FIFO that
// accepts up to N fetched slots per cycle and presents the oldest N in program order.

package instr_buffer_pkg;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] PC;
        logic [31:0] NPC;
        logic        predict_taken;
        logic [31:0] predict_target;
        logic        valid;
    } IF_ID_PACKET;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam IF_ID_PACKET NOP_PACKET = '{inst: NOP, default: '0};

endpackage

module instr_buffer
    import instr_buffer_pkg::*;
#(
    parameter int N     = 3,
    parameter int SIZE  = 16,
    parameter int CNT_W = $clog2(SIZE + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     squash,
    input  IF_ID_PACKET [N-1:0]      if_packet,
    input  logic [$clog2(N+1)-1:0]   consume_num,
    output IF_ID_PACKET [N-1:0]      id_packet,
    output logic [$clog2(N+1)-1:0]   accept_num,
    output logic [CNT_W-1:0]         free_slots,
    output logic [CNT_W-1:0]         count
);

    localparam int PTR_W = $clog2(SIZE);
    localparam int NUM_W = $clog2(N + 1);

    IF_ID_PACKET [SIZE-1:0] entries;
    logic [PTR_W-1:0]       head;
    logic [PTR_W-1:0]       tail;

    logic [NUM_W-1:0]       rank [N];
    logic [NUM_W-1:0]       num_valid;
    logic [NUM_W-1:0]       consume_eff;

    assign free_slots = CNT_W'(SIZE) - count;

    // Each valid slot's rank is its offset from tail once the valid slots are compacted.
    always_comb begin
        // NOTE: every variable gets a value before any branch, so no latch is inferred.
        num_valid = '0;
        for (int i = 0; i < N; i++) begin
            rank[i] = num_valid;
            if (if_packet[i].valid) begin
                num_valid = num_valid + 1'b1;
            end
        end
    end

    always_comb begin
        accept_num = '0;
        if (!squash) begin
            if (CNT_W'(num_valid) <= free_slots) begin
                accept_num = num_valid;
            end else begin
                accept_num = NUM_W'(free_slots);
            end
        end
    end

    // Over-consume is legal; only the occupied entries can leave.
    always_comb begin
        consume_eff = consume_num;
        if (CNT_W'(consume_num) > count) begin
            consume_eff = NUM_W'(count);
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset || squash) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(consume_eff);
            tail  <= tail + PTR_W'(accept_num);
            count <= count + CNT_W'(accept_num) - CNT_W'(consume_eff);
        end
    end

    // NOTE: the payload array is not reset; count alone decides which entries are live.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                if (if_packet[i].valid && (rank[i] < accept_num)) begin
                    entries[tail + PTR_W'(rank[i])] <= if_packet[i];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            id_packet[i] = NOP_PACKET;
            if (CNT_W'(i) < count) begin
                id_packet[i]       = entries[head + PTR_W'(i)];
                id_packet[i].valid = 1'b1;
            end
        end
    end

endmodule

// File: doc/instr_buffer.md
# instr_buffer

Circular FIFO between the fetch stage and `stage_decode`. It absorbs up to `N` fetched instructions per cycle and presents the oldest up to `N` instructions to decode in program order. It decouples fetch from dispatch stalls and provides per-cycle acceptance and consumption counts. On a squash it discards all buffered instructions.

## Interface
- `SIZE`, default 16: buffer depth in entries; power of two, `SIZE >= 2*N`.
- `CNT_W`, default `$clog2(SIZE+1)`: width of occupancy and free counters.
- `clock`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high; clears the buffer on the clock edge where it is high.
- `squash`  in  1: mispredict/exception flush; empties the buffer on the next edge.
- `if_packet`  in  `IF_ID_PACKET [N-1:0]`: fetched slots; `valid` bits need not be contiguous.
- `consume_num`  in  `$clog2(N+1)`: number of head entries taken by decode/dispatch this cycle.
- `id_packet`  out  `IF_ID_PACKET [N-1:0]`: oldest entries, slot 0 is the oldest; feeds `stage_decode`.
- `accept_num`  out  `$clog2(N+1)`: number of valid `if_packet` slots written this cycle.
- `free_slots`  out  `CNT_W`: `SIZE - count`, from registered state only.
- `count`  out  `CNT_W`: registered occupancy.

## Operation
- State:
  - `SIZE`-entry array of `IF_ID_PACKET`.
  - `head` and `tail` pointers, each `$clog2(SIZE)` bits, with natural power-of-two wrap.
  - `count` register.
- Enqueue:
  - Valid `if_packet` slots are compacted in ascending index order.
  - The first `min(num_valid, free_slots)` are written at `tail`, `tail+1`, … (mod `SIZE`).
  - Excess valid slots are dropped. `accept_num` reports the number written so fetch re-fetches from the first dropped PC.
- Dequeue:
  - Effective consume is `min(consume_num, count)`.
  - `head` advances by that amount mod `SIZE`.
- Occupancy update: `count_next = count + accept_num - consume_eff`. It never exceeds `SIZE` because acceptance is bounded by the pre-dequeue `free_slots`.
- Output:
  - `id_packet[i]` is the entry at `head+i` with `valid=1` for `i < min(count, N)`.
  - Every other slot has `valid=0`, `inst=`NOP``, and all other fields 0.
- Squash:
  - `head`, `tail`, and `count` go to 0. All enqueue and dequeue in that cycle are ignored.
  - `accept_num` is 0 while `squash` is high.
- Priority: `reset` > `squash` > normal enqueue/dequeue.
- Entry payload (`inst`, `PC`, `NPC`, `predict_taken`, `predict_target`, `valid`) is stored and returned unmodified.

## Timing
- Reset values:
  - `count=0`, `head=tail=0`, `free_slots=SIZE`, `accept_num=0`.
  - All `id_packet[i].valid=0`; stored entries need not be cleared.
- Latency: an instruction enqueued at edge k appears on `id_packet` in the cycle after edge k. Minimum fetch-to-decode latency is 1 cycle. There is no same-cycle bypass.
- `id_packet`, `count`, and `free_slots` depend only on registered state. There is no combinational path from `consume_num` or `if_packet` to them.
- `accept_num` is combinational from `if_packet`, `squash`, and registered `free_slots`.
- `consume_num` must be a function of the current `id_packet`. The buffer clamps it to `count`; over-consume is not an error.
- Full (`count=SIZE`): `accept_num=0`. A simultaneous dequeue frees space only from the next cycle.
- Empty: all outputs invalid; `consume_num` is ignored. Enqueue proceeds normally.
- Wrap-around: writes or reads that straddle index `SIZE-1→0` preserve order.
- Squash with valid input: input is discarded; the buffer is empty after the edge.
- Reset asserted mid-operation: the buffer is empty after that edge regardless of other inputs.

## Test plan
- Reset with `N=3`, `SIZE=16` → `count=0`, `free_slots=16`, all `id_packet.valid=0`. Then enqueue PCs 0x0, 0x4, 0x8 → next cycle `id_packet` PCs are 0x0, 0x4, 0x8 with valid 1,1,1 and `count=3`.
- Sparse input: `valid=3'b101` with PCs A, B, C → `accept_num=2`. Next cycle slot0=A, slot1=C, slot2 invalid.
- Fill to `count=15`, then present 3 valid → `accept_num=1`, `count=16`, `free_slots=0`. Next cycle 3 valid with `consume_num=3` → `accept_num=0`, `count=13`.
- Wrap: with `head=14`, `count=2`, enqueue 3 → entries land at 0, 1, 2. Output order after consuming 2 continues with the oldest new PC.
- Simultaneous enqueue of 3 and `consume_num=2` at `count=4` → `count=5`; output order is intact.
- Squash with `count=10` and 3 valid inputs → `accept_num=0`. Next cycle `count=0`, outputs invalid, `free_slots=16`. Repeat with `reset` instead → same result.
